mem_responder: RTL

Backing-memory responder for the cache controller's memory port. It accepts single-word read and write beats on the `wr_mem`/`rd_mem`/`addr_mem` interface and stalls each beat with `busy_mem` for a programmable number of wait cycles. Read data returns on `data_rd_mem`. It sits below the direct-mapped cache in simulation and demo builds, standing in for main memory, and counts the traffic it serves.

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/mem_resp_array.sv | 20 ++
 rtl/mem_responder.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared constants and request decode for the backing-memory responder.
package mem_resp_pkg;

  localparam int          WAIT_W       = 4;
  localparam int          MAX_LATENCY  = 15;
  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_t;

  // A beat with both strobes raised is served as a write.
  function automatic op_t decode_op(input logic rd, input logic wr);
    if (wr) return OP_WR;
    if (rd) return OP_RD;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word array: synchronous write, asynchronous read, no reset on contents.
module mem_resp_array #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] idx,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory stand-in: stalls every beat LATENCY cycles via combinational busy_mem; read data valid on the accept cycle.
// Optional address checking (bad beats flagged, writes dropped, reads return a marker) under MEM_RESP_ADDR_CHECK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_mem,
  input  logic        rd_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] data_wr_mem,
  output logic        busy_mem,
  output logic [31:0] data_rd_mem,
  output logic [31:0] rd_beat_count,
  output logic [31:0] wr_beat_count,
  output logic        mem_err
);

  localparam logic [WAIT_W-1:0] LAT = WAIT_W'(LATENCY);

  if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("mem_responder: LATENCY out of range");
  end

  op_t               op;
  logic              req;
  logic              accept;
  logic              addr_err;
  logic              arr_we;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DEPTH_W-1:0] idx;
  logic [31:0]       arr_rdata;

  assign op  = decode_op(rd_mem, wr_mem);
  assign req = rd_mem | wr_mem;
  assign idx = addr_mem[DEPTH_W+1:2];

  // Gating with rst makes busy drop and the beat vanish the moment reset asserts.
  assign busy_mem = rst && req && (wait_cnt != LAT);
  assign accept   = rst && req && (wait_cnt == LAT);
  assign arr_we   = accept && (op == OP_WR) && !addr_err;

  assign data_rd_mem = (accept && op == OP_RD) ? (addr_err ? MEM_ERR_DATA : arr_rdata) : 32'h0;

  mem_resp_array #(
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (idx),
    .wdata (data_wr_mem),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt      <= '0;
      rd_beat_count <= '0;
      wr_beat_count <= '0;
    end else begin
      // Count restarts on every accept and whenever the request drops.
      if (busy_mem) wait_cnt <= wait_cnt + 1'b1;
      else          wait_cnt <= '0;
      if (accept && op == OP_WR) wr_beat_count <= wr_beat_count + 32'd1;
      if (accept && op == OP_RD) rd_beat_count <= rd_beat_count + 32'd1;
    end
  end

`ifdef MEM_RESP_ADDR_CHECK_EN
  logic err_q;

  assign addr_err = (|addr_mem[31:DEPTH_W+2]) || (|addr_mem[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    err_q <= 1'b0;
    else if (accept && addr_err) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  logic unused_addr_bits;

  assign addr_err         = 1'b0;
  assign mem_err          = 1'b0;
  assign unused_addr_bits = ^{addr_mem[31:DEPTH_W+2], addr_mem[1:0]};
`endif

endmodule
